// File: rtl/mfcc_pkg.sv
// Shared constants for the MFCC front end: Q formats, log-compression defaults
// and the constant function that builds the log2 mantissa table.
package mfcc_pkg;

  localparam int Q_IN          = 30;
  localparam int Q_OUT         = 16;
  localparam int LN2_Q16_DEF   = 45426;
  localparam int FLOOR_Q16_DEF = -1362780;
  localparam int LUT_W         = 17;

  // round(log2(1 + i/2^lut_bits) * 2^16) by repeated squaring, integer-only so it
  // elaborates everywhere; 24 fraction bits are generated then rounded to 16.
  function automatic logic [LUT_W-1:0] log2_lut_entry(input int i, input int lut_bits);
    logic [63:0] x;
    logic [23:0] bits;
    logic [24:0] rounded;
    if (i >= (1 << lut_bits)) return LUT_W'(1 << Q_OUT);
    x    = (64'((1 << lut_bits) + i) << Q_IN) >> lut_bits;
    bits = '0;
    for (int k = 23; k >= 0; k--) begin
      x = (x * x) >> Q_IN;
      if (x >= (64'd2 << Q_IN)) begin
        bits[k] = 1'b1;
        x       = x >> 1;
      end
    end
    rounded = 25'(bits) + 25'd128;
    return LUT_W'(rounded >> 8);
  endfunction

endpackage

// File: rtl/log_compress_if.sv
// Streaming port bundle between the mel filterbank and the log-compression stage.
interface log_compress_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic [31:0] log_out;
  logic        log_valid;
  logic        frame_done;

  modport master (output data_in, data_valid, input log_out, log_valid, frame_done);
  modport slave  (input data_in, data_valid, output log_out, log_valid, frame_done);
endinterface

// File: rtl/log2_lut.sv
// Combinational log2 mantissa ROM returning the two neighbouring entries
// needed for linear interpolation.
module log2_lut
  import mfcc_pkg::*;
#(
  parameter int LUT_BITS = 6
) (
  input  logic [LUT_BITS-1:0] idx,
  output logic [LUT_W-1:0]    lut_lo,
  output logic [LUT_W-1:0]    lut_hi
);

  localparam int DEPTH = (1 << LUT_BITS) + 1;

  logic [LUT_W-1:0]  rom [DEPTH];
  logic [LUT_BITS:0] idx_lo;
  logic [LUT_BITS:0] idx_hi;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = log2_lut_entry(g, LUT_BITS);
  end

  assign idx_lo = {1'b0, idx};
  assign idx_hi = idx_lo + (LUT_BITS+1)'(1);
  assign lut_lo = rom[idx_lo];
  assign lut_hi = rom[idx_hi];

endmodule

// File: rtl/log_compress.sv
// Four-stage Q30 -> Q16 natural-log pipeline: classify, normalise/LUT,
// interpolate, scale by ln2; also marks the last filter of each frame.
module log_compress
  import mfcc_pkg::*;
#(
  parameter int NUM_FILTERS = 40,
  parameter int LUT_BITS    = 6,
  parameter int INTERP_BITS = 8,
  parameter int LN2_Q16     = LN2_Q16_DEF,
  parameter int FLOOR_Q16   = FLOOR_Q16_DEF
) (
  input  logic           clk,
  input  logic           rst,
  log_compress_if.slave  bus
);

  localparam int SEL_W = LUT_BITS + INTERP_BITS;
  localparam int CNT_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  // S1: capture, classify, leading-one position
  logic [4:0]  lod_pos;
  logic        s1_valid, s1_clamp;
  logic [30:0] s1_mag;
  logic [4:0]  s1_pos;

  // NOTE: always_comb uses blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    lod_pos = '0;
    for (int b = 0; b < 31; b++)
      if (bus.data_in[b]) lod_pos = 5'(b);
  end

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= bus.data_valid;
  end

  // NOTE: datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    s1_clamp <= bus.data_in[31] || (bus.data_in == 32'd0);
    s1_mag   <= bus.data_in[30:0];
    s1_pos   <= lod_pos;
  end

  // S2: shift the leading one to bit 30, split fraction into LUT index and weight
  logic [SEL_W-1:0]       s2_sel;
  logic [LUT_W-1:0]       lut_lo, lut_hi;
  logic                   s2_valid, s2_clamp;
  logic [LUT_W-1:0]       s2_lo, s2_hi;
  logic [INTERP_BITS-1:0] s2_t;
  logic signed [5:0]      s2_exp;

  assign s2_sel = SEL_W'((30'(s1_mag << (5'(Q_IN) - s1_pos))) >> (Q_IN - SEL_W));

  log2_lut #(.LUT_BITS(LUT_BITS)) u_lut (
    .idx    (s2_sel[SEL_W-1 -: LUT_BITS]),
    .lut_lo (lut_lo),
    .lut_hi (lut_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else     s2_valid <= s1_valid;
  end

  always_ff @(posedge clk) begin
    s2_clamp <= s1_clamp;
    s2_lo    <= lut_lo;
    s2_hi    <= lut_hi;
    s2_t     <= s2_sel[INTERP_BITS-1:0];
    s2_exp   <= $signed({1'b0, s1_pos}) - 6'sd30;
  end

  // S3: linear interpolation between neighbouring entries (table is monotonic)
  logic [LUT_W-1:0]   s3_frac;
  logic signed [22:0] s3_l2_d;
  logic               s3_valid, s3_clamp;
  logic signed [22:0] s3_l2;

  assign s3_frac = s2_lo + LUT_W'(((LUT_W+INTERP_BITS)'(s2_hi - s2_lo)
                                   * (LUT_W+INTERP_BITS)'(s2_t)) >> INTERP_BITS);
  assign s3_l2_d = (23'(s2_exp) <<< Q_OUT) + 23'(s3_frac);

  always_ff @(posedge clk) begin
    if (rst) s3_valid <= 1'b0;
    else     s3_valid <= s2_valid;
  end

  always_ff @(posedge clk) begin
    s3_clamp <= s2_clamp;
    s3_l2    <= s3_l2_d;
  end

  // S4: log2 -> ln with round-half-up, floor for non-positive input, frame count
  logic [31:0]      ln_round;
  logic [31:0]      log_out_q;
  logic             log_valid_q, frame_done_q;
  logic [CNT_W-1:0] frame_cnt;

  assign ln_round = 32'((41'(s3_l2) * 41'(LN2_Q16) + 41'sd32768) >>> Q_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      log_out_q    <= '0;
      log_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      log_valid_q  <= s3_valid;
      frame_done_q <= 1'b0;
      if (s3_valid) begin
        log_out_q <= s3_clamp ? 32'(FLOOR_Q16) : ln_round;
        if (frame_cnt == CNT_W'(NUM_FILTERS - 1)) begin
          frame_done_q <= 1'b1;
          frame_cnt    <= '0;
        end else begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.log_out    = log_out_q;
  assign bus.log_valid  = log_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_log_compress.sv
// Scoreboard bench for log_compress: stimulus pushes expected results, an
// independent monitor pops and compares whenever log_valid is seen.
module tb_log_compress;

  localparam int    NUM_FILTERS = 40;
  localparam int    LUT_BITS    = 6;
  localparam int    INTERP_BITS = 8;
  localparam int    LN2_Q16     = 45426;
  localparam int    FLOOR_Q16   = -1362780;
  localparam int    LATENCY     = 4;
  localparam real   ACC_TOL     = 8.0;  // table + truncated-weight envelope vs true ln

  typedef struct {
    int          lo;
    int          hi;
    bit          fd;
    int          cyc;
    bit          acc;
    logic [31:0] x;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   stim_cnt;
  exp_t sb[$];
  exp_t mon_e;
  real  mon_err;

  log_compress_if bus ();

  log_compress #(
    .NUM_FILTERS (NUM_FILTERS),
    .LUT_BITS    (LUT_BITS),
    .INTERP_BITS (INTERP_BITS),
    .LN2_Q16     (LN2_Q16),
    .FLOOR_Q16   (FLOOR_Q16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference: real-valued table, then the normalise/index/interpolate/scale rules.
  function automatic int lut_ref(input int i);
    return $rtoi($floor($ln(1.0 + real'(i) / real'(1 << LUT_BITS)) / $ln(2.0) * 65536.0 + 0.5));
  endfunction

  function automatic int model_ln(input logic [31:0] x);
    longint m, f, l2, prod;
    int     p, idx, t, lo, hi;
    if ($signed(x) <= 0) return FLOOR_Q16;
    p    = $clog2(longint'(x) + 1) - 1;
    m    = longint'(x) << (30 - p);
    f    = m - (longint'(1) << 30);
    idx  = int'(f >> (30 - LUT_BITS));
    t    = int'((f >> (30 - LUT_BITS - INTERP_BITS)) % (1 << INTERP_BITS));
    lo   = lut_ref(idx);
    hi   = lut_ref(idx + 1);
    l2   = longint'(p - 30) * 65536 + lo + ((hi - lo) * t) / (1 << INTERP_BITS);
    prod = l2 * LN2_Q16 + 32768;
    return int'(prod >>> 16);
  endfunction

  task automatic send(input logic [31:0] x, input int lo, input int hi, input bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.data_in    = x;
    bus.data_valid = 1'b1;
    e.lo  = lo;
    e.hi  = hi;
    e.fd  = (stim_cnt == NUM_FILTERS - 1);
    e.cyc = cyc;
    e.acc = acc;
    e.x   = x;
    stim_cnt = e.fd ? 0 : stim_cnt + 1;
    sb.push_back(e);
  endtask

  task automatic send_model(input logic [31:0] x);
    int m;
    m = model_ln(x);
    if ($signed(x) <= 0) send(x, FLOOR_Q16, FLOOR_Q16, 1'b0);
    else                 send(x, m - 1, m + 1, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.data_valid = 1'b0;
      bus.data_in    = $urandom();
    end
  endtask

  function automatic logic [31:0] rand_pos();
    logic [31:0] x;
    x = ($urandom() & 32'h7FFF_FFFF) >> $urandom_range(0, 30);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    sb.delete();
    stim_cnt = 0;
    @(posedge clk);
    #1;
    check("reset_log_valid", bus.log_valid == 1'b0, $sformatf("got %0b want 0", bus.log_valid));
    check("reset_frame_done", bus.frame_done == 1'b0, $sformatf("got %0b want 0", bus.frame_done));
    check("reset_log_out", bus.log_out == 32'd0, $sformatf("got %0d want 0", $signed(bus.log_out)));
    rst = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (bus.log_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1'b0,
              $sformatf("log_valid with log_out=%0d but nothing expected", $signed(bus.log_out)));
      end else begin
        mon_e = sb.pop_front();
        check("log_out", $signed(bus.log_out) >= mon_e.lo && $signed(bus.log_out) <= mon_e.hi,
              $sformatf("x=%h got %0d want %0d..%0d", mon_e.x, $signed(bus.log_out), mon_e.lo, mon_e.hi));
        check("frame_done", bus.frame_done == mon_e.fd,
              $sformatf("x=%h got %0b want %0b", mon_e.x, bus.frame_done, mon_e.fd));
        check("latency", cyc - mon_e.cyc == LATENCY,
              $sformatf("x=%h got %0d want %0d", mon_e.x, cyc - mon_e.cyc, LATENCY));
        if (mon_e.acc) begin
          mon_err = real'($signed(bus.log_out)) - $ln(real'(mon_e.x) / 1073741824.0) * 65536.0;
          check("accuracy", mon_err <= ACC_TOL && mon_err >= -ACC_TOL,
                $sformatf("x=%h got %0d error %f LSB limit %f", mon_e.x, $signed(bus.log_out), mon_err, ACC_TOL));
        end
      end
    end else if (bus.frame_done) begin
      check("frame_done_alone", 1'b0, "got frame_done=1 without log_valid, want 0");
    end
  end

  initial begin
    logic [31:0] x;
    rst            = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    stim_cnt       = 0;
    repeat (3) @(posedge clk);
    #1;
    check("init_log_valid", bus.log_valid == 1'b0, $sformatf("got %0b want 0", bus.log_valid));
    check("init_frame_done", bus.frame_done == 1'b0, $sformatf("got %0b want 0", bus.frame_done));
    check("init_log_out", bus.log_out == 32'd0, $sformatf("got %0d want 0", $signed(bus.log_out)));
    rst = 1'b0;

    // Exact points, clamps and near-max, back to back
    send(32'h4000_0000, 0, 0, 1'b1);
    send(32'h2000_0000, -45426, -45426, 1'b1);
    send(32'h0000_0001, FLOOR_Q16, FLOOR_Q16, 1'b1);
    send(32'h0000_0000, FLOOR_Q16, FLOOR_Q16, 1'b0);
    send(32'h8000_0000, FLOOR_Q16, FLOOR_Q16, 1'b0);
    send(32'h7FFF_FFFF, 45423, 45426, 1'b1);
    send(32'h6000_0000, 26572 - 3, 26572 + 3, 1'b1);
    idle(6);

    // One frame back to back, then two frames with random gaps
    do_reset();
    for (int i = 0; i < NUM_FILTERS; i++) send_model(rand_pos());
    idle(2);
    for (int i = 0; i < 2 * NUM_FILTERS; i++) begin
      send_model(rand_pos());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(6);

    // Reset with three samples in flight; the next frame restarts from zero
    send_model(rand_pos());
    send_model(rand_pos());
    send_model(rand_pos());
    do_reset();
    for (int i = 0; i < NUM_FILTERS; i++) send_model(rand_pos());
    idle(6);

    // Random sweep, occasional non-positive inputs and gaps
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 49) == 0) x = ($urandom_range(0, 1) == 0) ? 32'd0 : ($urandom() | 32'h8000_0000);
      else                            x = rand_pos();
      send_model(x);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    check("drain", sb.size() == 0, $sformatf("got %0d outstanding results, want 0", sb.size()));
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
